sobel_stream_edge: RTL and testbench
====================================

Name: sobel_stream_edge

Overview:
- Streaming, synthesizable Sobel edge detector. Replaces the file-driven 512x512 batch detector in the image path.
- Accepts one raster-order pixel per handshake. Buffers two previous lines in on-chip line buffers and forms a 3x3 window.
- Emits one thresholded edge bit per interior window position, so each frame yields (IMG_W-2)x(IMG_H-2) results.
- Image size, pixel depth and threshold are parameters, not fixed constants.

Parameters:
- IMG_W, 512, pixels per line (>=3)
- IMG_H, 512, lines per frame (>=3)
- PIX_W, 8, bits per input pixel (1..12)
- THRESH, 4, edge asserted when magnitude > THRESH (unsigned, PIX_W+3 bits)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present
- in_ready  out  1  block can accept a pixel
- in_pix  in  PIX_W  unsigned pixel value
- in_sof  in  1  marks the first pixel of a frame; qualified by in_valid&&in_ready
- out_valid  out  1  edge result present
- out_ready  in  1  downstream accepts the result
- out_edge  out  1  1 = edge at the window centre
- out_last  out  1  last result of the frame
- frame_done  out  1  one-cycle pulse when the last input pixel of a frame is accepted

Behaviour:
- Reset (async, immediate): out_valid, out_edge, out_last, frame_done = 0; col/row counters = 0; window registers = 0. Line buffer contents are don't-care.
- in_ready = !out_valid || out_ready (combinational). It is 1 after reset.
- Accept: in_valid && in_ready. On accept:
  - shift the window;
  - write in_pix to line buffer 0 at address col, moving the old entry to line buffer 1;
  - advance col. When col = IMG_W-1, col wraps to 0 and row increments. When row also = IMG_H-1, row wraps to 0 and frame_done pulses.
- in_sof on an accepted pixel forces that pixel to be treated as (row 0, col 0), discarding any partial frame.
- Window at accept of (r,c): p11..p33 = pixels (r-2..r, c-2..c), centre (r-1,c-1).
- Output generation: an accept with r>=2 and c>=2 registers a result. out_valid goes to 1 the next cycle, giving 1-cycle latency. Accepts with r<2 or c<2 produce nothing, so no stale or cross-line data ever reaches the output.
- Arithmetic, signed, PIX_W+3 bits:
  - gx = (p31+2p32+p33) - (p11+2p12+p13)
  - gy = (p13+2p23+p33) - (p11+2p21+p31)
  - mag = |gx|+|gy|, unsigned PIX_W+3 bits, no saturation needed (max 8*(2^PIX_W-1))
  - out_edge = (mag > THRESH)
- Output register: loaded when a result is generated. Held stable while out_valid && !out_ready. Cleared (out_valid=0) on out_ready with no new result the same cycle. A simultaneous pop and new result reloads the register in the same cycle.
- out_last = 1 with the result whose centre is (IMG_H-2, IMG_W-2).
- No state machine beyond the counters. The frame boundary is seamless: pixel (0,0) of the next frame may be accepted the cycle after frame_done.
- Reset mid-frame: all in-flight results are dropped, and the next accepted pixel is (0,0).
- Line buffers: depth IMG_W, one read and one write per accept; must infer RAM.

Optional Feature:
- Macro SOBEL_MAG_OUT_EN.
- When defined: adds output port out_mag [PIX_W+3-1:0], registered together with out_edge and following the same hold rules. Reset value 0.
- When undefined: the port is absent and mag is used only for the comparison.

Test Plan:
- Config for all cases: IMG_W=8, IMG_H=6, PIX_W=8, THRESH=4.
- Flat frame, all pixels 100, out_ready=1 -> exactly 24 results, all out_edge=0; out_last only on the 24th; frame_done pulses once on the 48th accept.
- Vertical step: cols 0-3=0, cols 4-7=255 -> each result row reads 0,0,1,1,0,0 (centres 3 and 4 have gy=1020). With SOBEL_MAG_OUT_EN, out_mag=1020 at those centres.
- Horizontal ramp pix=col:
  - THRESH=8 -> all 24 results 0 (mag=8, strict compare);
  - rebuilt with THRESH=7 -> all 24 results 1.
- Backpressure: step frame with out_ready low for 3 cycles mid-row -> out_valid/out_edge stay constant, in_ready=0, no extra accepts; sequence identical to the no-stall case.
- Reset mid-frame: assert rst after 20 accepts -> outputs 0 in the same cycle. Next full flat frame gives exactly 24 results with out_last on the last.
- in_sof asserted on the 30th pixel of a frame -> counters restart; the following 48 pixels produce 24 correct results and one frame_done.

Source files
------------

// File: rtl/sobel_stream_edge.sv
// Streaming 3x3 Sobel edge detector with two line buffers and a registered, backpressured output.
// Optional SOBEL_MAG_OUT_EN adds the out_mag port carrying the gradient magnitude.
module sobel_stream_edge #(
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_edge,
  output logic             out_last,
  output logic             frame_done
`ifdef SOBEL_MAG_OUT_EN
  ,
  output logic [PIX_W+2:0] out_mag
`endif
);

  localparam int unsigned MW = PIX_W + 3;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [MW-1:0] THR = MW'(THRESH);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];

  // Columns c-2 (pX1) and c-1 (pX2) of the window; column c comes from the buffers and in_pix.
  logic [PIX_W-1:0] r_p11, r_p12, r_p21, r_p22, r_p31, r_p32;

  logic          r_out_valid;
  logic          r_out_edge;
  logic          r_out_last;
  logic          r_frame_done;
  logic [MW-1:0] r_out_mag;

  logic             w_acc;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;
  logic [MW-1:0]    w_gx;
  logic [MW-1:0]    w_gy;
  logic [MW-1:0]    w_ax;
  logic [MW-1:0]    w_ay;
  logic [MW-1:0]    w_mag;
  logic             w_gen;
  logic             w_last_pix;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_lb0_rd   = r_lb0[w_col];
  assign w_lb1_rd   = r_lb1[w_col];
  assign w_last_pix = (w_col == COL_LAST) && (w_row == ROW_LAST);
  assign w_gen      = w_acc && (w_row >= RW'(2)) && (w_col >= CW'(2));

  always_comb begin
    w_gx = (MW'(r_p31) + MW'({r_p32, 1'b0}) + MW'(in_pix))
         - (MW'(r_p11) + MW'({r_p12, 1'b0}) + MW'(w_lb1_rd));
    w_gy = (MW'(w_lb1_rd) + MW'({w_lb0_rd, 1'b0}) + MW'(in_pix))
         - (MW'(r_p11) + MW'({r_p21, 1'b0}) + MW'(r_p31));
    w_ax  = w_gx[MW-1] ? (MW'(0) - w_gx) : w_gx;
    w_ay  = w_gy[MW-1] ? (MW'(0) - w_gy) : w_gy;
    w_mag = w_ax + w_ay;
  end

  // No reset on the line buffers so they map onto RAM.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_col] <= in_pix;
      r_lb1[w_col] <= w_lb0_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_p11 <= '0;
      r_p12 <= '0;
      r_p21 <= '0;
      r_p22 <= '0;
      r_p31 <= '0;
      r_p32 <= '0;
    end else if (w_acc) begin
      r_p11 <= r_p12;
      r_p12 <= w_lb1_rd;
      r_p21 <= r_p22;
      r_p22 <= w_lb0_rd;
      r_p31 <= r_p32;
      r_p32 <= in_pix;
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_edge   <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_mag    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_last_pix;
      if (w_gen) begin
        r_out_valid <= 1'b1;
        r_out_edge  <= (w_mag > THR);
        r_out_last  <= w_last_pix;
        r_out_mag   <= w_mag;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_edge  <= 1'b0;
        r_out_last  <= 1'b0;
        r_out_mag   <= '0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_edge   = r_out_edge;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
`ifdef SOBEL_MAG_OUT_EN
  assign out_mag    = r_out_mag;
`else
  logic w_mag_unused;
  assign w_mag_unused = ^r_out_mag;
`endif

endmodule

// File: tb/tb_sobel_stream_edge.sv
// Directed bench for sobel_stream_edge on an 8x6 image; three instances differ only in THRESH.
module tb_sobel_stream_edge;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_pix = 8'd0;

  logic rdy_a, ov_a, oe_a, ol_a, fd_a;
  logic rdy_b, ov_b, oe_b, ol_b, fd_b;
  logic rdy_c, ov_c, oe_c, ol_c, fd_c;
  int   mg_a, mg_b, mg_c;

`ifdef SOBEL_MAG_OUT_EN
  logic [10:0] om_a, om_b, om_c;
  assign mg_a = int'(om_a);
  assign mg_b = int'(om_b);
  assign mg_c = int'(om_c);
`else
  assign mg_a = 0;
  assign mg_b = 0;
  assign mg_c = 0;
`endif

  always #5 clk = ~clk;

  sobel_stream_edge #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(ov_a), .out_ready(out_ready), .out_edge(oe_a),
    .out_last(ol_a), .frame_done(fd_a)
`ifdef SOBEL_MAG_OUT_EN
    , .out_mag(om_a)
`endif
  );

  sobel_stream_edge #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(ov_b), .out_ready(out_ready), .out_edge(oe_b),
    .out_last(ol_b), .frame_done(fd_b)
`ifdef SOBEL_MAG_OUT_EN
    , .out_mag(om_b)
`endif
  );

  sobel_stream_edge #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(7)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(ov_c), .out_ready(out_ready), .out_edge(oe_c),
    .out_last(ol_c), .frame_done(fd_c)
`ifdef SOBEL_MAG_OUT_EN
    , .out_mag(om_c)
`endif
  );

  // Results are recorded as mag*4 + last*2 + edge.
  int q_a[$];
  int q_b[$];
  int q_c[$];
  int n_acc = 0;
  int n_fd = 0;
  int n_rdy_diff = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && rdy_a) n_acc <= n_acc + 1;
      if (fd_a) n_fd <= n_fd + 1;
      if ((rdy_b != rdy_a) || (rdy_c != rdy_a) || (fd_b != fd_a) || (fd_c != fd_a))
        n_rdy_diff <= n_rdy_diff + 1;
      if (ov_a && out_ready) q_a.push_back(mg_a * 4 + (ol_a ? 2 : 0) + (oe_a ? 1 : 0));
      if (ov_b && out_ready) q_b.push_back(mg_b * 4 + (ol_b ? 2 : 0) + (oe_b ? 1 : 0));
      if (ov_c && out_ready) q_c.push_back(mg_c * 4 + (ol_c ? 2 : 0) + (oe_c ? 1 : 0));
    end
  end

  typedef struct {
    int         pat;
    int         stall_idx;
    logic [0:5] exp_a;
    logic [0:5] exp_b;
    logic [0:5] exp_c;
    int         mag_on;
    int         mag_off;
  } vec_t;

  vec_t vecs[4];
  int   n_checks = 0;
  int   n_fail = 0;
  int   b_a, b_b, b_c, b_acc, b_fd;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic mark();
    b_a   = q_a.size();
    b_b   = q_b.size();
    b_c   = q_c.size();
    b_acc = n_acc;
    b_fd  = n_fd;
  endtask

  function automatic logic [7:0] pix_of(input int pat, input int c);
    logic [7:0] v;
    case (pat)
      0:       v = 8'd100;
      1:       v = (c >= 4) ? 8'd255 : 8'd0;
      default: v = 8'(c);
    endcase
    return v;
  endfunction

  task automatic send_pix(input logic [7:0] p, input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pix   = p;
    in_sof   = sof;
    @(negedge clk);
    while (!rdy_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_pix timeout: in_ready stuck at 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_stall(input logic [7:0] p);
    int base;
    base     = n_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pix   = p;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", i), int'(ov_a), 1);
      chk($sformatf("stall%0d out_edge", i), int'(oe_a), 1);
      chk($sformatf("stall%0d in_ready", i), int'(rdy_a), 0);
      chk($sformatf("stall%0d accepts", i), n_acc - base, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic send_frame(input int pat, input logic sof_first, input int stall_idx);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c == stall_idx) do_stall(pix_of(pat, c));
        send_pix(pix_of(pat, c), sof_first && (r == 0) && (c == 0));
      end
    end
  endtask

  task automatic check_frame(input vec_t v, input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " count_a"}, q_a.size() - b_a, 24);
    chk({nm, " count_b"}, q_b.size() - b_b, 24);
    chk({nm, " count_c"}, q_c.size() - b_c, 24);
    for (int i = 0; i < 24; i++) begin
      int k;
      k = i % 6;
      if (b_a + i < q_a.size()) begin
        chk($sformatf("%s edge_a[%0d]", nm, i), q_a[b_a + i] & 1, int'(v.exp_a[k]));
        chk($sformatf("%s last[%0d]", nm, i), (q_a[b_a + i] >> 1) & 1, (i == 23) ? 1 : 0);
`ifdef SOBEL_MAG_OUT_EN
        chk($sformatf("%s mag[%0d]", nm, i), q_a[b_a + i] >> 2,
            v.exp_a[k] ? v.mag_on : v.mag_off);
`endif
      end
      if (b_b + i < q_b.size())
        chk($sformatf("%s edge_b[%0d]", nm, i), q_b[b_b + i] & 1, int'(v.exp_b[k]));
      if (b_c + i < q_c.size())
        chk($sformatf("%s edge_c[%0d]", nm, i), q_c[b_c + i] & 1, int'(v.exp_c[k]));
    end
    chk({nm, " frame_done"}, n_fd - b_fd, 1);
    chk({nm, " accepts"}, n_acc - b_acc, 48);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // pat, stall_idx, exp_a (T=4), exp_b (T=8), exp_c (T=7), mag where exp_a=1, mag elsewhere
    vecs[0] = '{0, -1, 6'b000000, 6'b000000, 6'b000000, 0, 0};
    vecs[1] = '{1, -1, 6'b001100, 6'b001100, 6'b001100, 1020, 0};
    vecs[2] = '{2, -1, 6'b111111, 6'b000000, 6'b111111, 8, 8};
    vecs[3] = '{1, 21, 6'b001100, 6'b001100, 6'b001100, 1020, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(ov_a), 0);
    chk("reset out_last", int'(ol_a), 0);
    chk("reset frame_done", int'(fd_a), 0);
    chk("reset in_ready", int'(rdy_a), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      mark();
      send_frame(vecs[v].pat, 1'b1, vecs[v].stall_idx);
      check_frame(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset after 20 accepts; the next frame carries no in_sof.
    for (int i = 0; i < 20; i++) send_pix(8'd100, i == 0);
    chk("prerst out_valid", int'(ov_a), 1);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(ov_a), 0);
    chk("midrst out_last", int'(ol_a), 0);
    chk("midrst in_ready", int'(rdy_a), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mark();
    send_frame(0, 1'b0, -1);
    check_frame(vecs[0], "after_rst");

    // Abandon a frame after 29 pixels, restart with in_sof.
    for (int i = 0; i < 29; i++) send_pix(8'd100, i == 0);
    repeat (2) @(posedge clk);
    #1;
    mark();
    send_frame(1, 1'b1, -1);
    check_frame(vecs[1], "sof_restart");

    chk("instances agree on in_ready/frame_done", n_rdy_diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
